psum_requant_drain: RTL

//  Downstream stage of the partial-sum accumulator buffer. On start, scans all
//  H*W accumulated entries in raster order through a 1-cycle-latency read port.

---
 rtl/npu_pkg.sv | 60 ++++++
 rtl/requant_fifo2.sv | 57 +++++
 rtl/psum_requant_drain.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, drain FSM state type and the requantisation function
// used by the psum drain stage.
//   DATA_WIDTH : accumulator / psum width (signed)
//   OUT_WIDTH  : quantised output width (signed)
//   ADDR_W     : psum buffer linear address width
// Optional macro QUANT_ROUND_EN: round-half-up before the right shift
// (adds 2^(shift-1) when shift>0, adder widened by one bit). Without it the
// shift truncates toward -inf.
package npu_pkg;

  localparam int DATA_WIDTH = 24;
  localparam int OUT_WIDTH  = 8;
  localparam int ADDR_W     = 8;

  // bias + psum never overflows in one extra bit
  localparam int SUM_W = DATA_WIDTH + 1;
`ifdef QUANT_ROUND_EN
  // rounding offset needs one more bit of headroom
  localparam int ACC_W = SUM_W + 1;
`else
  localparam int ACC_W = SUM_W;
`endif

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } drain_state_t;

  // s: bias-adjusted psum; returns shifted, optionally ReLU'd, saturated value
  function automatic logic signed [OUT_WIDTH-1:0] requant(
    input logic signed [SUM_W-1:0] s,
    input logic [4:0]              shift,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] t;
    acc = ACC_W'(s);
`ifdef QUANT_ROUND_EN
    if (shift != 5'd0) begin
      acc = acc + (ACC_W'(1) << (shift - 5'd1));
    end
`endif
    t = acc >>> shift;
    if (relu && t[ACC_W-1]) begin
      t = '0;
    end
    if (t > SAT_MAX) begin
      return SAT_MAX[OUT_WIDTH-1:0];
    end else if (t < SAT_MIN) begin
      return SAT_MIN[OUT_WIDTH-1:0];
    end
    return t[OUT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/requant_fifo2.sv
// requant_fifo2: two-entry valid/ready FIFO holding {data, addr} results.
// Simultaneous write and pop keep the occupancy unchanged. The head entry is
// a plain register read, so it stays stable while rd_valid && !rd_ready.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_en, wr_data      push (caller guarantees the FIFO is not full)
//   rd_valid, rd_ready  head handshake; pop on rd_valid && rd_ready
//   rd_data             head entry
//   count               occupancy 0..2
module requant_fifo2 #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_reg [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic          pop;

  assign rd_valid = (count_reg != 2'd0);
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/psum_requant_drain.sv
// psum_requant_drain: drains an H x W partial-sum buffer in raster order,
// requantises each entry (bias add, arithmetic shift, optional ReLU,
// saturation to OUT_WIDTH) and streams {data, addr} on valid/ready.
// done and psum_clear pulse together once the last result has been accepted.
// Data/address widths come from npu_pkg. Optional macro QUANT_ROUND_EN
// (see npu_pkg) selects round-half-up instead of truncation.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   start                   begin a drain (only honoured in IDLE)
//   bias, shift, relu_en    quantisation settings, captured on start
//   busy                    drain in progress (DRAIN/FLUSH)
//   done, psum_clear        one-cycle completion pulse
//   rd_en, rd_addr          psum buffer read port request
//   rd_data                 psum value, one cycle after rd_en
//   out_valid, out_ready    result handshake
//   out_data, out_addr      quantised result and its linear address
module psum_requant_drain
  import npu_pkg::*;
#(
  parameter int H = 12,
  parameter int W = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] bias,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  psum_clear,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0]     out_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H * W - 1);

  drain_state_t state_reg, state_next;

  logic [ADDR_W-1:0]             rd_addr_reg;
  logic                          inflight_reg;
  logic [ADDR_W-1:0]             inflight_addr_reg;
  logic signed [DATA_WIDTH-1:0]  bias_reg;
  logic [4:0]                    shift_reg;
  logic                          relu_reg;

  logic                          issue;
  logic                          pop;
  logic [1:0]                    fifo_count;
  logic [1:0]                    occ;
  logic signed [SUM_W-1:0]       sum;
  logic signed [OUT_WIDTH-1:0]   q;
  logic [OUT_WIDTH+ADDR_W-1:0]   fifo_rd_data;

  assign pop = out_valid && out_ready;
  // FIFO entries plus the read still on its way from the buffer
  assign occ = fifo_count + {1'b0, inflight_reg};

  assign sum = SUM_W'($signed(rd_data)) + SUM_W'(bias_reg);
  assign q   = requant(sum, shift_reg, relu_reg);

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (occ < 2'd2) begin
          issue = 1'b1;
          if (rd_addr_reg == LAST_ADDR) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        // leave as the final entry is popped so done follows it by one cycle
        if (!inflight_reg &&
            ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      rd_addr_reg       <= '0;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= '0;
      bias_reg          <= '0;
      shift_reg         <= '0;
      relu_reg          <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= issue;
      if (state_reg == IDLE && start) begin
        bias_reg    <= $signed(bias);
        shift_reg   <= shift;
        relu_reg    <= relu_en;
        rd_addr_reg <= '0;
      end
      if (issue) begin
        inflight_addr_reg <= rd_addr_reg;
        // hold at the last address rather than wrapping
        if (rd_addr_reg != LAST_ADDR) begin
          rd_addr_reg <= rd_addr_reg + 1'b1;
        end
      end
    end
  end

  assign busy       = (state_reg == DRAIN) || (state_reg == FLUSH);
  assign done       = (state_reg == DONE);
  assign psum_clear = (state_reg == DONE);
  assign rd_en      = issue;
  assign rd_addr    = rd_addr_reg;

  requant_fifo2 #(
    .DW(OUT_WIDTH + ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (inflight_reg),
    .wr_data  ({q, inflight_addr_reg}),
    .rd_valid (out_valid),
    .rd_ready (out_ready),
    .rd_data  (fifo_rd_data),
    .count    (fifo_count)
  );

  assign out_data = fifo_rd_data[ADDR_W +: OUT_WIDTH];
  assign out_addr = fifo_rd_data[ADDR_W-1:0];

endmodule
